// File: rtl/dds_pkg.sv
// Shared constants and state encoding for the DDS chain (sine table, PWM generator, PWM decoder).
package dds_pkg;

  localparam int ROM_WIDTH_DEF = 8;
  localparam int CNT_W         = 2 * ROM_WIDTH_DEF;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_e;

  // Measurement counters are twice the sample width so a full-scale period fits.
  function automatic int cnt_width(input int rom_width);
    return 2 * rom_width;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic s_o,
  output logic rise_o
);

  logic meta_q;
  logic s_q;
  logic s_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      meta_q  <= d_i;
      s_q     <= meta_q;
      s_dly_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~s_dly_q;

endmodule

// File: rtl/pwm_decoder.sv
// Measures high time and period of each PWM cycle between rising edges.
// o_ce is a one-cycle valid with no ready: data_high/data_period/o_timeout are valid while o_ce is high and hold until the next o_ce or reset.
module pwm_decoder
  import dds_pkg::*;
#(
  parameter int ROM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pwm_in,
  output logic                   o_ce,
  output logic [2*ROM_WIDTH-1:0] data_high,
  output logic [2*ROM_WIDTH-1:0] data_period,
  output logic                   o_timeout,
  output logic                   dbg_state_o
);

  localparam int CW = cnt_width(ROM_WIDTH);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic s;
  logic rise;

  meas_state_e   state_q, state_d;
  logic [CW-1:0] cnt_period_q, cnt_period_d;
  logic [CW-1:0] cnt_high_q, cnt_high_d;
  logic [CW-1:0] data_high_q, data_high_d;
  logic [CW-1:0] data_period_q, data_period_d;
  logic          timeout_q, timeout_d;
  logic          ce_q, ce_d;

  sync_edge_det u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (pwm_in),
    .s_o    (s),
    .rise_o (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_period_q  <= '0;
      cnt_high_q    <= '0;
      data_high_q   <= '0;
      data_period_q <= '0;
      timeout_q     <= 1'b0;
      ce_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_period_q  <= cnt_period_d;
      cnt_high_q    <= cnt_high_d;
      data_high_q   <= data_high_d;
      data_period_q <= data_period_d;
      timeout_q     <= timeout_d;
      ce_q          <= ce_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_period_d  = cnt_period_q;
    cnt_high_d    = cnt_high_q;
    data_high_d   = data_high_q;
    data_period_d = data_period_q;
    timeout_d     = timeout_q;
    ce_d          = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_period_d = '0;
        cnt_high_d   = '0;
        if (rise) begin
          state_d      = MEASURE;
          cnt_period_d = ONE;
          cnt_high_d   = ONE;
        end
      end
      MEASURE: begin
        // The edge cycle closes the old period and is also the first cycle of the new one.
        if (rise) begin
          data_period_d = cnt_period_q;
          data_high_d   = cnt_high_q;
          timeout_d     = 1'b0;
          ce_d          = 1'b1;
          cnt_period_d  = ONE;
          cnt_high_d    = ONE;
        end else if (cnt_period_q == CMAX) begin
          data_period_d = CMAX;
          data_high_d   = cnt_high_q;
          timeout_d     = 1'b1;
          ce_d          = 1'b1;
          state_d       = IDLE;
          cnt_period_d  = '0;
          cnt_high_d    = '0;
        end else begin
          cnt_period_d = cnt_period_q + ONE;
          cnt_high_d   = cnt_high_q + {{(CW-1){1'b0}}, s};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ce        = ce_q;
  assign data_high   = data_high_q;
  assign data_period = data_period_q;
  assign o_timeout   = timeout_q;
  assign dbg_state_o = (state_q == MEASURE);

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: two instances (ROM_WIDTH 8 and 4) checked every cycle against a sample-level model.
module tb_pwm_decoder;

  localparam int CMAX0 = 65535;
  localparam int CMAX1 = 255;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        pwm0, pwm1;
  logic        o_ce0, o_ce1, o_timeout0, o_timeout1, dbg0, dbg1;
  logic [15:0] data_high0, data_period0;
  logic [7:0]  data_high1, data_period1;

  pwm_decoder #(.ROM_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .pwm_in(pwm0), .o_ce(o_ce0),
    .data_high(data_high0), .data_period(data_period0),
    .o_timeout(o_timeout0), .dbg_state_o(dbg0)
  );

  pwm_decoder #(.ROM_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .pwm_in(pwm1), .o_ce(o_ce1),
    .data_high(data_high1), .data_period(data_period1),
    .o_timeout(o_timeout1), .dbg_state_o(dbg1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] mk(input bit to, input int hi, input int per);
    return {to, hi[15:0], per[15:0]};
  endfunction

  // model: results derived from the sampled waveform, delayed two edges for synchronization
  typedef struct {bit v; bit to; int hi; int per;} ev_t;
  ev_t ev1[2], ev2[2];
  bit  m_act[2], m_prev[2], m_ce[2], m_to[2];
  int  m_start[2], m_ones[2], m_hi[2], m_per[2];
  int  kcyc = 0;

  task automatic model_step(input int id, input bit x);
    ev_t nev;
    int  cm;
    int  el;
    bit  rise;
    cm  = (id == 0) ? CMAX0 : CMAX1;
    nev = '{v: 1'b0, to: 1'b0, hi: 0, per: 0};
    if (rst) begin
      m_act[id] = 0; m_prev[id] = 0; m_ce[id] = 0; m_to[id] = 0;
      m_hi[id] = 0; m_per[id] = 0; ev1[id] = nev; ev2[id] = nev;
      return;
    end
    m_ce[id] = ev2[id].v;
    if (ev2[id].v) begin
      m_to[id] = ev2[id].to; m_hi[id] = ev2[id].hi; m_per[id] = ev2[id].per;
    end
    ev2[id] = ev1[id];
    rise = x && !m_prev[id];
    if (m_act[id]) begin
      el = kcyc - m_start[id];
      if (rise) begin
        nev = '{v: 1'b1, to: 1'b0, hi: m_ones[id], per: el};
        m_start[id] = kcyc; m_ones[id] = 1;
      end else if (el == cm) begin
        nev = '{v: 1'b1, to: 1'b1, hi: m_ones[id], per: cm};
        m_act[id] = 0;
      end else begin
        m_ones[id] += int'(x);
      end
    end else if (rise) begin
      m_act[id] = 1; m_start[id] = kcyc; m_ones[id] = 1;
    end
    m_prev[id] = x;
    ev1[id] = nev;
  endtask

  always @(posedge clk) begin
    kcyc++;
    model_step(0, pwm0);
    model_step(1, pwm1);
  end

  // compare process: every cycle, plus a log of every strobe for the literal checks
  logic [32:0] got0[$], got1[$];
  logic [32:0] exp_q[$];

  always @(negedge clk) begin
    chk("ce0", o_ce0, m_ce[0]);
    chk("high0", data_high0, m_hi[0]);
    chk("period0", data_period0, m_per[0]);
    chk("timeout0", o_timeout0, m_to[0]);
    chk("ce1", o_ce1, m_ce[1]);
    chk("high1", data_high1, m_hi[1]);
    chk("period1", data_period1, m_per[1]);
    chk("timeout1", o_timeout1, m_to[1]);
    if (o_ce0 === 1'b1) got0.push_back({o_timeout0, data_high0, data_period0});
    if (o_ce1 === 1'b1) got1.push_back({o_timeout1, 8'h00, data_high1, 8'h00, data_period1});
  end

  // driver tasks: inputs change on the falling edge
  task automatic drive(input int id, input int hi, input int per);
    for (int i = 0; i < per; i++) begin
      if (id == 0) pwm0 = (i < hi); else pwm1 = (i < hi);
      @(negedge clk);
    end
  endtask

  task automatic hold(input int id, input bit val, input int n);
    for (int i = 0; i < n; i++) begin
      if (id == 0) pwm0 = val; else pwm1 = val;
      @(negedge clk);
    end
  endtask

  task automatic score(input int id, input string nm);
    int          n;
    logic [32:0] g;
    n = (id == 0) ? got0.size() : got1.size();
    chk({nm, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = '0;
      if (i < n) g = (id == 0) ? got0[i] : got1[i];
      chk(nm, g, exp_q[i]);
    end
    exp_q.delete();
    if (id == 0) got0.delete(); else got1.delete();
  endtask

  initial begin
    rst = 1'b1; pwm0 = 1'b0; pwm1 = 1'b0;
    @(negedge clk);
    chk("rst_ce0", o_ce0, 0);
    chk("rst_high0", data_high0, 0);
    chk("rst_period0", data_period0, 0);
    chk("rst_timeout0", o_timeout0, 0);
    chk("rst_state0", dbg0, 0);
    chk("rst_ce1", o_ce1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // steady 256/64: ten rising edges give nine results
    repeat (10) drive(0, 64, 256);
    repeat (9) exp_q.push_back(mk(0, 64, 256));
    score(0, "steady");

    // duty step 64 -> 192 at a period boundary
    repeat (2) drive(0, 64, 256);
    repeat (2) drive(0, 192, 256);
    drive(0, 64, 256);
    repeat (3) exp_q.push_back(mk(0, 64, 256));
    repeat (2) exp_q.push_back(mk(0, 192, 256));
    score(0, "step");

    // reset mid-period
    hold(0, 0, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ce", o_ce0, 0);
    chk("midrst_high", data_high0, 0);
    chk("midrst_period", data_period0, 0);
    chk("midrst_timeout", o_timeout0, 0);
    got0.delete();
    repeat (2) drive(0, 64, 256);
    exp_q.push_back(mk(0, 64, 256));
    score(0, "after_rst");

    // minimum period
    repeat (6) drive(0, 1, 2);
    hold(0, 0, 10);
    exp_q.push_back(mk(0, 64, 256));
    repeat (5) exp_q.push_back(mk(0, 1, 2));
    score(0, "min_period");

    // stuck low after one pulse (CNT_MAX 255)
    drive(1, 40, 400);
    hold(1, 0, 50);
    exp_q.push_back(mk(1, 40, 255));
    score(1, "stuck_low");
    chk("stuck_low_idle", dbg1, 0);

    // stuck high
    hold(1, 1, 400);
    hold(1, 0, 20);
    exp_q.push_back(mk(1, 255, 255));
    score(1, "stuck_high");

    // edge exactly at CNT_MAX wins over timeout, then a real timeout
    repeat (3) drive(1, 10, 255);
    hold(1, 0, 300);
    repeat (2) exp_q.push_back(mk(0, 10, 255));
    exp_q.push_back(mk(1, 10, 255));
    score(1, "edge_at_max");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
